// File: rtl/mips_bus_ram_slave_pkg.sv
// mips_bus_pkg: RAM slave FSM states, reset vector and bus/storage byte-lane swap
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} ram_state_t;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  function automatic logic [31:0] lane_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/mips_bus_ram_slave_if.sv
// mips_bus_ram_slave_if: CPU-side request/response bus between master and RAM slave
interface mips_bus_ram_slave_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        err;
  modport master (output address, read, write, writedata, byteenable, input waitrequest, readdata, err);
  modport slave (input address, read, write, writedata, byteenable, output waitrequest, readdata, err);
endinterface

// File: rtl/mips_bus_ram_slave_lfsr.sv
// bus_lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 on reset
module bus_lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 16'hACE1;
    else if (step) q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end
endmodule

// File: rtl/mips_bus_ram_slave.sv
// mips_bus_ram_slave: word RAM slave with fixed waitrequest latency and LE bus / BE storage lanes.
// Define MIPS_BUS_RAM_STALL_INJECT_EN to add up to 3 LFSR-driven extra stall cycles per transfer.
module mips_bus_ram_slave
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  mips_bus_ram_slave_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  logic [31:0] mem [DEPTH_WORDS];
  ram_state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0] stalls, stalls_n;
  logic [29:0] word_off;
  logic [AW-1:0] idx;
  logic [31:0] rd_word, readdata_q;
  logic req, null_addr, oor, bad, wr_ok, enter_ack, stall, err_q;
  assign req = bus.read | bus.write;
  assign word_off = 30'((bus.address - ADDR_BASE) >> 2);
  assign idx = word_off[AW-1:0];
  assign null_addr = bus.address == 32'd0;
  assign oor = !null_addr && ({2'b00, word_off} >= 32'(DEPTH_WORDS));
  assign bad = oor | (bus.read & bus.write);
  assign wr_ok = bus.write & ~bus.read & ~null_addr & ~oor;
  assign rd_word = lane_swap(mem[idx]);
  assign bus.readdata = readdata_q;
  assign bus.err = err_q;
`ifdef MIPS_BUS_RAM_STALL_INJECT_EN
  logic [15:0] lfsr;
  bus_lfsr16 u_lfsr (.clk(clk), .reset(reset), .step(1'b1), .q(lfsr));
  assign stall = lfsr[0] && (stalls != 2'd3);
`else
  assign stall = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    stalls_n = stalls;
    enter_ack = 1'b0;
    bus.waitrequest = 1'b0;
    case (state)
      IDLE: begin
        bus.waitrequest = req;
        stalls_n = '0;
        if (req && WAIT_CYCLES > 1) begin
          state_n = WAIT;
          cnt_n = 16'(WAIT_CYCLES - 2);
        end else if (req && stall) begin
          state_n = WAIT;
          cnt_n = '0;
          stalls_n = 2'd1;
        end else if (req) begin
          state_n = ACK;
          enter_ack = 1'b1;
        end
      end
      WAIT: begin
        bus.waitrequest = 1'b1;
        if (!req) state_n = IDLE;
        else if (cnt != 16'd0) cnt_n = cnt - 16'd1;
        else if (stall) stalls_n = stalls + 2'd1;
        else begin
          state_n = ACK;
          enter_ack = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (reset) bus.waitrequest = 1'b0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      stalls <= '0;
      readdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      stalls <= stalls_n;
      if (enter_ack && bad) err_q <= 1'b1;
      for (int n = 0; n < 4; n++)
        if (enter_ack && bus.byteenable[n] && (bus.read || bad))
          readdata_q[8*n +: 8] <= (bad || null_addr) ? 8'h00 : rd_word[8*n +: 8];
    end
  end
  // RAM is never reset; a write lands on the edge that closes ACK
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++)
      if (!reset && state == ACK && wr_ok && bus.byteenable[n])
        mem[idx][8*(3-n) +: 8] <= bus.writedata[8*n +: 8];
  end
endmodule
